imem_loader: RTL and testbench
==============================

# imem_loader

Byte-serial boot loader that fills the CPU's instruction memory before execution. It accepts a framed byte stream (count header, little-endian instruction words, XOR checksum) on a valid/ready interface. It issues one write per assembled 32-bit word into the instruction RAM port that the core reads by word address, and holds the core while loading. It sits between the board input path (UART receiver or switch-entry front end) and the write port of the instruction memory.

## Interface
- XLEN, 32, instruction word width
- ADDR_WIDTH, 6, instruction memory word-address width
- MAX_WORDS, 64, largest accepted program length in words (≤ 2^ADDR_WIDTH, ≤ 255)

- clk  in  1  CPU-domain clock
- rst  in  1  reset; one clock, synchronous, active-high (fixed)
- start  in  1  single-cycle pulse; begins a new load frame
- byte_valid  in  1  byte_data holds a byte
- byte_data  in  8  stream byte
- byte_ready  out  1  loader can accept a byte this cycle
- im_we  out  1  instruction memory write strobe, one cycle per word
- im_addr  out  ADDR_WIDTH  word address of the write
- im_wdata  out  XLEN  word written
- cpu_hold  out  1  core must not advance PC / fetch while high
- done  out  1  frame loaded and checksum matched (level)
- err  out  1  frame rejected (level)
- word_cnt  out  8  words written in the current/last frame

## Operation
- States: IDLE, HDR, DATA, CHK, DONE, ERR.
- Accept = byte_valid && byte_ready. byte_ready = 1 exactly in HDR, DATA, CHK.
- IDLE/DONE/ERR + start → HDR. The transition clears done, err, word_cnt, byte lane, and the checksum accumulator, and sets cpu_hold. start in HDR/DATA/CHK is ignored.
- HDR: the accepted byte is N.
  - N == 0 or N > MAX_WORDS → ERR.
  - Otherwise latch N, seed chk = N, go to DATA.
- DATA:
  - Each accepted byte goes into lane 0..3 of an assembly register, little-endian (first byte → bits [7:0]), and chk ^= byte.
  - On the 4th byte, the word is registered and written. im_addr = word_cnt (before increment), then word_cnt increments and the lane resets to 0.
  - After the Nth word → CHK.
- CHK: the accepted byte is compared to chk.
  - Equal → DONE: done=1, cpu_hold=0.
  - Unequal → ERR: err=1, cpu_hold stays 1.
- DONE: holds until start. ERR: holds until start or rst; the core stays held.
- Address arithmetic: word_cnt is 8-bit. im_addr = word_cnt[ADDR_WIDTH-1:0]. It never wraps, because N ≤ MAX_WORDS is enforced at the header.

## Timing
- Reset values: state IDLE. byte_ready, im_we, cpu_hold, done, err = 0. im_addr, im_wdata, word_cnt = 0.
- start is sampled at a clock edge; byte_ready is high in the next cycle.
- Write latency: im_we is high in the cycle after the edge that accepts a word's 4th byte. im_addr and im_wdata are valid in that same cycle. im_we is high for exactly 1 cycle per word.
- The loader accepts one byte per cycle at full rate. Valid gaps of any length are tolerated; the lane and chk are unchanged while byte_valid=0.
- done/err assert in the cycle after the edge that accepts the checksum byte. cpu_hold falls in that same cycle on success.
- For the last word, the CHK byte may be accepted in the very cycle im_we is high. Both events take effect.
- rst mid-frame aborts the frame at the next edge. All outputs return to their reset values, and no further im_we is issued. Already-written words are not erased.
- start coincident with rst: rst wins.

## Test plan
- Reset: hold rst 2 cycles with random inputs → all outputs 0, byte_ready 0, no im_we.
- Good frame: start, then bytes 02, 13,05,50,00, 93,05,60,00, B2 back-to-back →
  - im_we at addr 0 with 0x00500513, then at addr 1 with 0x00600593
  - done=1, err=0, word_cnt=2, cpu_hold 1→0 one cycle after B2 is accepted.
- Same frame with random byte_valid gaps and checksum B3 →
  - same two writes
  - err=1, done=0, cpu_hold remains 1
  - a subsequent start clears err.
- Header 00, and separately header MAX_WORDS+1 (65) → ERR one cycle after the header, zero im_we pulses, byte_ready 0.
- rst asserted after 5 payload bytes of a 2-word frame → exactly one im_we (addr 0) before rst, none after, all outputs at reset values.
- start pulsed mid-DATA is ignored (lane and word_cnt unaffected). A full MAX_WORDS=64 frame writes addresses 0..63 in order with no wrap, then done=1.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-serial boot loader: parses a framed stream (count, little-endian words,
// XOR checksum) and writes each assembled word into the instruction memory.
module imem_loader #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 6,
  parameter int MAX_WORDS  = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_data_i,
  output logic                  byte_ready_o,
  output logic                  im_we_o,
  output logic [ADDR_WIDTH-1:0] im_addr_o,
  output logic [XLEN-1:0]       im_wdata_o,
  output logic                  cpu_hold_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [7:0]            word_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [7:0] MAX_LEN = 8'(MAX_WORDS);

  state_e                state_q,      state_d;
  logic [7:0]            n_q,          n_d;
  logic [1:0]            lane_q,       lane_d;
  logic [23:0]           asm_q,        asm_d;
  logic [7:0]            chk_q,        chk_d;
  logic [7:0]            word_cnt_q,   word_cnt_d;
  logic                  im_we_q,      im_we_d;
  logic [ADDR_WIDTH-1:0] im_addr_q,    im_addr_d;
  logic [XLEN-1:0]       im_wdata_q,   im_wdata_d;
  logic                  cpu_hold_q,   cpu_hold_d;
  logic                  done_q,       done_d;
  logic                  err_q,        err_d;
  logic                  byte_ready_q, byte_ready_d;

  logic       accept;
  logic [7:0] cnt_inc;

  assign accept  = byte_valid_i && byte_ready_q;
  assign cnt_inc = word_cnt_q + 8'd1;

  always_comb begin
    // NOTE: every next-state value gets a default up front so no path through
    // the case below leaves a variable unassigned (which would infer a latch).
    state_d    = state_q;
    n_d        = n_q;
    lane_d     = lane_q;
    asm_d      = asm_q;
    chk_d      = chk_q;
    word_cnt_d = word_cnt_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    cpu_hold_d = cpu_hold_q;
    done_d     = done_q;
    err_d      = err_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          state_d    = S_HDR;
          done_d     = 1'b0;
          err_d      = 1'b0;
          word_cnt_d = 8'd0;
          lane_d     = 2'd0;
          chk_d      = 8'd0;
          cpu_hold_d = 1'b1;
        end
      end

      S_HDR: begin
        if (accept) begin
          if (byte_data_i == 8'd0 || byte_data_i > MAX_LEN) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            n_d     = byte_data_i;
            chk_d   = byte_data_i;
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          chk_d = chk_q ^ byte_data_i;
          unique case (lane_q)
            2'd0: asm_d[7:0]   = byte_data_i;
            2'd1: asm_d[15:8]  = byte_data_i;
            2'd2: asm_d[23:16] = byte_data_i;
            default: begin
              im_we_d    = 1'b1;
              im_addr_d  = word_cnt_q[ADDR_WIDTH-1:0];
              im_wdata_d = XLEN'({byte_data_i, asm_q});
              word_cnt_d = cnt_inc;
              if (cnt_inc == n_q) state_d = S_CHK;
            end
          endcase
          lane_d = lane_q + 2'd1;
        end
      end

      S_CHK: begin
        if (accept) begin
          if (byte_data_i == chk_q) begin
            state_d    = S_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Ready is registered against the next state so it is glitch-free.
    byte_ready_d = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CHK);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q      <= S_IDLE;
      n_q          <= 8'd0;
      lane_q       <= 2'd0;
      asm_q        <= 24'd0;
      chk_q        <= 8'd0;
      word_cnt_q   <= 8'd0;
      im_we_q      <= 1'b0;
      im_addr_q    <= '0;
      im_wdata_q   <= '0;
      cpu_hold_q   <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      byte_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      lane_q       <= lane_d;
      asm_q        <= asm_d;
      chk_q        <= chk_d;
      word_cnt_q   <= word_cnt_d;
      im_we_q      <= im_we_d;
      im_addr_q    <= im_addr_d;
      im_wdata_q   <= im_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      err_q        <= err_d;
      byte_ready_q <= byte_ready_d;
    end
  end

  assign byte_ready_o = byte_ready_q;
  assign im_we_o      = im_we_q;
  assign im_addr_o    = im_addr_q;
  assign im_wdata_o   = im_wdata_q;
  assign cpu_hold_o   = cpu_hold_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign word_cnt_o   = word_cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: good/bad frames, header
// rejection, mid-frame reset, ignored start and a full-length frame.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready_o, im_we_o, cpu_hold_o, done_o, err_o;
  logic [5:0]  im_addr_o;
  logic [31:0] im_wdata_o;
  logic [7:0]  word_cnt_o;

  int passed = 0;
  int total  = 0;

  logic [5:0]  wa[$];
  logic [31:0] wd[$];

  imem_loader #(.XLEN(32), .ADDR_WIDTH(6), .MAX_WORDS(64)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .byte_valid_i(byte_valid), .byte_data_i(byte_data),
    .byte_ready_o(byte_ready_o), .im_we_o(im_we_o), .im_addr_o(im_addr_o),
    .im_wdata_o(im_wdata_o), .cpu_hold_o(cpu_hold_o), .done_o(done_o),
    .err_o(err_o), .word_cnt_o(word_cnt_o)
  );

  always #5 clk = ~clk;

  // Write-port monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (im_we_o === 1'b1) begin
      wa.push_back(im_addr_o);
      wd.push_back(im_wdata_o);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    byte_valid = 1'b0; start = 1'b0; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    wa.delete(); wd.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited;
    waited = 0;
    byte_valid = 1'b1; byte_data = b;
    @(negedge clk);
    while (byte_ready_o !== 1'b1 && waited < 20) begin
      @(negedge clk); waited++;
    end
    if (waited >= 20) begin
      total++;
      $display("FAIL send_byte_timeout byte=%02h ready=%b required 1", b, byte_ready_o);
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic gap();
    int n;
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin
      byte_data = 8'($urandom);
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start = 1'($urandom); byte_valid = 1'($urandom); byte_data = 8'($urandom);
      tick();
    end
    rst = 1'b0; start = 1'b0; byte_valid = 1'b0;
    total++; if (byte_ready_o !== 1'b0) $display("FAIL reset_ready got %b want 0", byte_ready_o); else passed++;
    total++; if ({im_we_o, cpu_hold_o, done_o, err_o} !== 4'b0)
      $display("FAIL reset_flags got we/hold/done/err=%b want 0000", {im_we_o, cpu_hold_o, done_o, err_o}); else passed++;
    total++; if ({im_addr_o, im_wdata_o, word_cnt_o} !== 46'd0)
      $display("FAIL reset_buses got addr=%0h wdata=%0h cnt=%0d want 0", im_addr_o, im_wdata_o, word_cnt_o); else passed++;
    total++; if (wa.size() != 0) $display("FAIL reset_no_write got %0d writes want 0", wa.size()); else passed++;
    wa.delete(); wd.delete();
  endtask

  task automatic test_good_frame();
    logic [7:0] pay [8] = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h60, 8'h00};
    do_reset();
    pulse_start();
    total++; if (byte_ready_o !== 1'b1 || cpu_hold_o !== 1'b1)
      $display("FAIL good_start got ready=%b hold=%b want 1 1", byte_ready_o, cpu_hold_o); else passed++;
    send_byte(8'h02);
    for (int i = 0; i < 8; i++) begin
      send_byte(pay[i]);
      if (i == 3) begin
        total++; if (im_we_o !== 1'b1 || im_addr_o !== 6'd0 || im_wdata_o !== 32'h00500513)
          $display("FAIL good_w0 got we=%b addr=%0d data=%08h want 1 0 00500513", im_we_o, im_addr_o, im_wdata_o); else passed++;
      end
    end
    total++; if (im_we_o !== 1'b1 || im_addr_o !== 6'd1 || im_wdata_o !== 32'h00600593)
      $display("FAIL good_w1 got we=%b addr=%0d data=%08h want 1 1 00600593", im_we_o, im_addr_o, im_wdata_o); else passed++;
    total++; if (cpu_hold_o !== 1'b1) $display("FAIL good_hold_before got %b want 1", cpu_hold_o); else passed++;
    send_byte(8'hB2);
    total++; if (done_o !== 1'b1 || err_o !== 1'b0)
      $display("FAIL good_done got done=%b err=%b want 1 0", done_o, err_o); else passed++;
    total++; if (cpu_hold_o !== 1'b0 || word_cnt_o !== 8'd2 || byte_ready_o !== 1'b0)
      $display("FAIL good_final got hold=%b cnt=%0d ready=%b want 0 2 0", cpu_hold_o, word_cnt_o, byte_ready_o); else passed++;
    tick();
    total++; if (wa.size() != 2) $display("FAIL good_write_count got %0d want 2", wa.size()); else passed++;
  endtask

  task automatic test_bad_checksum();
    logic [7:0] frame [10] = '{8'h02, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h60, 8'h00, 8'hB3};
    do_reset();
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      gap();
      send_byte(frame[i]);
    end
    total++; if (err_o !== 1'b1 || done_o !== 1'b0 || cpu_hold_o !== 1'b1)
      $display("FAIL badchk_flags got err=%b done=%b hold=%b want 1 0 1", err_o, done_o, cpu_hold_o); else passed++;
    tick();
    total++; if (wa.size() != 2 || wa[0] !== 6'd0 || wd[0] !== 32'h00500513 || wa[1] !== 6'd1 || wd[1] !== 32'h00600593)
      $display("FAIL badchk_writes got n=%0d want 2 writes 0:00500513 1:00600593", wa.size()); else passed++;
    pulse_start();
    total++; if (err_o !== 1'b0 || byte_ready_o !== 1'b1 || word_cnt_o !== 8'd0)
      $display("FAIL badchk_restart got err=%b ready=%b cnt=%0d want 0 1 0", err_o, byte_ready_o, word_cnt_o); else passed++;
  endtask

  task automatic test_bad_header(input logic [7:0] hdr);
    do_reset();
    pulse_start();
    send_byte(hdr);
    total++; if (err_o !== 1'b1 || byte_ready_o !== 1'b0 || done_o !== 1'b0)
      $display("FAIL badhdr_%02h got err=%b ready=%b done=%b want 1 0 0", hdr, err_o, byte_ready_o, done_o); else passed++;
    byte_valid = 1'b1; tick(); tick(); byte_valid = 1'b0;
    total++; if (wa.size() != 0 || cpu_hold_o !== 1'b1)
      $display("FAIL badhdr_%02h_nowrite got writes=%0d hold=%b want 0 1", hdr, wa.size(), cpu_hold_o); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] frame [6] = '{8'h02, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93};
    do_reset();
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(frame[i]);
    rst = 1'b1; tick(); rst = 1'b0;
    total++; if ({byte_ready_o, im_we_o, cpu_hold_o, done_o, err_o} !== 5'b0 || {im_addr_o, im_wdata_o, word_cnt_o} !== 46'd0)
      $display("FAIL midrst_outputs got ready=%b we=%b hold=%b cnt=%0d addr=%0h want all 0",
               byte_ready_o, im_we_o, cpu_hold_o, word_cnt_o, im_addr_o); else passed++;
    for (int i = 0; i < 10; i++) begin
      byte_valid = 1'b1; byte_data = 8'($urandom); tick();
    end
    byte_valid = 1'b0;
    total++; if (wa.size() != 1 || wa[0] !== 6'd0 || wd[0] !== 32'h00500513)
      $display("FAIL midrst_writes got n=%0d want 1 write addr 0", wa.size()); else passed++;
  endtask

  task automatic test_start_ignored_and_max();
    logic [7:0]  chk;
    logic [7:0]  b [4];
    logic [31:0] exp_w [64];
    int          bad;
    do_reset();
    pulse_start();
    send_byte(8'd64);
    chk = 8'd64;
    for (int i = 0; i < 64; i++) begin
      b[0] = 8'(i); b[1] = 8'(i) ^ 8'hA5; b[2] = ~8'(i); b[3] = 8'(i) + 8'h10;
      exp_w[i] = {b[3], b[2], b[1], b[0]};
      for (int k = 0; k < 4; k++) begin
        send_byte(b[k]);
        chk = chk ^ b[k];
        if (i == 0 && k == 1) begin
          pulse_start();
          total++; if (byte_ready_o !== 1'b1 || word_cnt_o !== 8'd0 || err_o !== 1'b0)
            $display("FAIL ignstart got ready=%b cnt=%0d err=%b want 1 0 0", byte_ready_o, word_cnt_o, err_o); else passed++;
        end
      end
    end
    send_byte(chk);
    total++; if (done_o !== 1'b1 || err_o !== 1'b0 || word_cnt_o !== 8'd64 || cpu_hold_o !== 1'b0)
      $display("FAIL max_done got done=%b err=%b cnt=%0d hold=%b want 1 0 64 0", done_o, err_o, word_cnt_o, cpu_hold_o); else passed++;
    tick();
    total++; if (wa.size() != 64) $display("FAIL max_write_count got %0d want 64", wa.size()); else passed++;
    bad = 0;
    for (int i = 0; i < 64 && i < wa.size(); i++)
      if (wa[i] !== 6'(i) || wd[i] !== exp_w[i]) begin
        if (bad == 0) $display("FAIL max_write_%0d got addr=%0d data=%08h want %0d %08h", i, wa[i], wd[i], i, exp_w[i]);
        bad++;
      end
    total++; if (bad != 0) $display("FAIL max_writes got %0d bad writes want 0", bad); else passed++;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_bad_header(8'h00);
    test_bad_header(8'd65);
    test_reset_mid_frame();
    test_start_ignored_and_max();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
